// File: rtl/master_led_pkg.sv
// Shared definitions for the LED driver: register map, reset values and
// the full-brightness duty code.
package master_led_pkg;

    typedef enum logic [1:0] {
        CTRL         = 2'd0,
        DUTY         = 2'd1,
        BLINK_PERIOD = 2'd2,
        BLINK_MASK   = 2'd3
    } reg_addr_e;

    localparam logic       CTRL_RST  = 1'b1;
    localparam logic [7:0] DUTY_RST  = 8'hFF;
    localparam int         BLINK_RST = 0;
    localparam logic [7:0] DUTY_FULL = 8'hFF;

endpackage

// File: rtl/master_led_tick_gen.sv
// PWM step prescaler: emits a one-clock tick every PRESCALE clocks while
// enabled, and sits at zero while disabled so a re-enable starts a full step.
module master_led_tick_gen #(
    parameter int PRESCALE = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/master_led_driver.sv
// LED output stage behind the PIO: global PWM brightness and per-LED blink,
// configured through a zero-wait Avalon-MM slave.
module master_led_driver
    import master_led_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 64,
    parameter int BLINK_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] led_out
);

    logic               ctrl_en;
    logic [7:0]         duty;
    logic [BLINK_W-1:0] blink_period;
    logic [WIDTH-1:0]   blink_mask;

    logic [7:0]         duty_shadow;
    logic [7:0]         pwm_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [WIDTH-1:0]   pattern_q;

    logic tick;
    logic period_end;
    logic pwm_on;
    logic wr;
    logic wr_blink_period;

    assign wr              = chipselect && !write_n;
    assign wr_blink_period = wr && (reg_addr_e'(address) == BLINK_PERIOD);
    assign period_end      = tick && (pwm_cnt == 8'hFF);
    assign pwm_on          = (duty_shadow == DUTY_FULL) || (pwm_cnt < duty_shadow);

    master_led_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (ctrl_en),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en      <= CTRL_RST;
            duty         <= DUTY_RST;
            blink_period <= BLINK_W'(BLINK_RST);
            blink_mask   <= '0;
        end else if (wr) begin
            case (reg_addr_e'(address))
                CTRL:         ctrl_en      <= writedata[0];
                DUTY:         duty         <= writedata[7:0];
                BLINK_PERIOD: blink_period <= writedata[BLINK_W-1:0];
                BLINK_MASK:   blink_mask   <= writedata[WIDTH-1:0];
                default:      ;
            endcase
        end
    end

    // Shadowed duty only changes at a period boundary so a brightness change never chops a pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt     <= '0;
            duty_shadow <= DUTY_RST;
        end else begin
            if (!ctrl_en) begin
                pwm_cnt <= '0;
            end else if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (period_end || !ctrl_en) begin
                duty_shadow <= duty;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!ctrl_en || blink_period == '0 || wr_blink_period) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (period_end) begin
            if (blink_cnt == blink_period - BLINK_W'(1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= '0;
            led_out   <= '0;
        end else begin
            pattern_q <= pattern_in;
            led_out   <= {WIDTH{ctrl_en & pwm_on}} & pattern_q
                       & (~blink_mask | {WIDTH{blink_phase}});
        end
    end

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        readdata = '0;
        case (reg_addr_e'(address))
            CTRL:         readdata[0]           = ctrl_en;
            DUTY:         readdata[7:0]         = duty;
            BLINK_PERIOD: readdata[BLINK_W-1:0] = blink_period;
            BLINK_MASK: begin
                readdata[WIDTH-1:0] = blink_mask;
                readdata[WIDTH]     = blink_phase;
            end
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_master_led_driver.sv
// Self-checking bench for master_led_driver with a timeline-based reference
// model (elapsed enabled cycles and completed PWM periods).
module tb_master_led_driver;

    localparam int P = 4;
    localparam int PERIOD = 256 * P;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  pattern_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  led_out;

    int checks = 0;
    int errors = 0;

    master_led_driver #(
        .WIDTH(8),
        .PRESCALE(P),
        .BLINK_W(16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pattern_in(pattern_in),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    // Reference model: m_t = clocks since the PWM timeline (re)started,
    // m_ends = PWM periods completed since the blink timeline (re)started.
    bit          m_en     = 1'b1;
    logic [7:0]  m_duty   = 8'hFF;
    logic [15:0] m_bp     = 16'd0;
    logic [7:0]  m_mask   = 8'h00;
    logic [7:0]  m_shadow = 8'hFF;
    logic [7:0]  m_pq     = 8'h00;
    logic [7:0]  m_led    = 8'h00;
    int          m_t      = 0;
    int          m_ends   = 0;
    int          m_step;
    bit          m_pend, m_on, m_ph, m_wr;

    function automatic bit m_phase();
        if (m_bp == 16'd0) return 1'b1;
        return ((m_ends / int'(m_bp)) % 2) == 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {31'd0, m_en};
            2'd1:    return {24'd0, m_duty};
            2'd2:    return {16'd0, m_bp};
            default: return {23'd0, m_phase(), m_mask};
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_en = 1'b1; m_duty = 8'hFF; m_bp = 16'd0; m_mask = 8'h00;
            m_shadow = 8'hFF; m_pq = 8'h00; m_led = 8'h00; m_t = 0; m_ends = 0;
        end else begin
            m_step = (m_t / P) % 256;
            m_pend = m_en && (m_t % P == P - 1) && (m_step == 255);
            m_on   = (m_shadow == 8'hFF) || (m_step < int'(m_shadow));
            m_ph   = m_phase();
            m_led  = (m_en && m_on) ? (m_pq & (~m_mask | {8{m_ph}})) : 8'h00;
            m_pq   = pattern_in;
            if (m_pend || !m_en) m_shadow = m_duty;
            m_t    = m_en ? m_t + 1 : 0;
            m_wr   = chipselect && !write_n;
            if (!m_en || m_bp == 16'd0 || (m_wr && address == 2'd2)) m_ends = 0;
            else if (m_pend) m_ends = m_ends + 1;
            if (m_wr) begin
                case (address)
                    2'd0:    m_en   = writedata[0];
                    2'd1:    m_duty = writedata[7:0];
                    2'd2:    m_bp   = writedata[15:0];
                    default: m_mask = writedata[7:0];
                endcase
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (led_out !== 8'h00) begin
            errors++; $display("FAIL reset_led got %h exp 00", led_out);
        end
        checks++;
        if (readdata !== 32'd1) begin
            errors++; $display("FAIL reset_ctrl got %h exp 00000001", readdata);
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (led_out !== 8'h00) begin
            errors++; $display("FAIL latency_1clk got %h exp 00", led_out);
        end
        @(negedge clk);
        checks++;
        if (led_out !== 8'hA5) begin
            errors++; $display("FAIL latency_2clk got %h exp a5", led_out);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            checks++;
            if (led_out !== 8'hA5 || led_out !== m_led) begin
                errors++; $display("FAIL transparent cyc %0d got %h exp a5/%h", i, led_out, m_led);
            end
        end
    endtask

    task automatic test_pwm_duty();
        int highs;
        pattern_in = 8'hFF;
        bus_write(2'd1, 32'd64);
        bus_write(2'd0, 32'd0);
        bus_write(2'd0, 32'd1);
        repeat (8) @(negedge clk);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (led_out == 8'hFF) highs++;
            checks++;
            if (led_out !== m_led) begin
                errors++; $display("FAIL pwm64 cyc %0d got %h exp %h", i, led_out, m_led);
            end
        end
        checks++;
        if (highs != 256) begin
            errors++; $display("FAIL pwm64_count got %0d exp 256", highs);
        end
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'd0);
        bus_write(2'd0, 32'd1);
        highs = 0;
        for (int i = 0; i < PERIOD + 8; i++) begin
            @(negedge clk);
            if (led_out != 8'h00) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++; $display("FAIL pwm0_count got %0d exp 0", highs);
        end
    endtask

    task automatic test_duty_update();
        bus_write(2'd1, 32'd64);
        bus_write(2'd0, 32'd0);
        bus_write(2'd0, 32'd1);
        repeat (300) @(negedge clk);
        bus_write(2'd1, 32'd128);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (led_out !== 8'h00) begin
                errors++; $display("FAIL duty_hold cyc %0d got %h exp 00", i, led_out);
            end
        end
        address = 2'd1;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            checks++;
            if (led_out !== m_led || readdata !== m_read(address)) begin
                errors++;
                $display("FAIL duty_next cyc %0d got %h/%h exp %h/%h", i, led_out, readdata, m_led, m_read(address));
            end
        end
    endtask

    task automatic test_blink();
        int   toggles;
        logic prev;
        pattern_in = 8'hFF;
        bus_write(2'd1, 32'hFF);
        bus_write(2'd3, 32'h0F);
        bus_write(2'd0, 32'd0);
        bus_write(2'd0, 32'd1);
        bus_write(2'd2, 32'd2);
        address = 2'd3;
        toggles = 0;
        prev = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (readdata[8] !== prev) toggles++;
            prev = readdata[8];
            checks++;
            if (led_out !== m_led || readdata !== m_read(address)) begin
                errors++;
                $display("FAIL blink cyc %0d got %h/%h exp %h/%h", i, led_out, readdata, m_led, m_read(address));
            end
            if (i >= 4 && led_out[7:4] !== 4'hF) begin
                checks++; errors++;
                $display("FAIL blink_high_nibble cyc %0d got %h exp f", i, led_out[7:4]);
            end
        end
        checks++;
        if (toggles != 2) begin
            errors++; $display("FAIL blink_toggles got %0d exp 2", toggles);
        end
    endtask

    task automatic test_disable();
        bus_write(2'd2, 32'd0);
        bus_write(2'd1, 32'hFF);
        bus_write(2'd0, 32'd0);
        bus_write(2'd0, 32'd1);
        repeat (10) @(negedge clk);
        checks++;
        if (led_out !== 8'hFF) begin
            errors++; $display("FAIL lit_before_disable got %h exp ff", led_out);
        end
        bus_write(2'd1, 32'd64);
        bus_write(2'd2, 32'd1);
        repeat (PERIOD + 50) @(negedge clk);
        bus_write(2'd0, 32'd0);
        address = 2'd3;
        @(negedge clk);
        checks++;
        if (led_out !== 8'h00 || readdata[8] !== 1'b1) begin
            errors++; $display("FAIL disable got led %h phase %b exp 00 1", led_out, readdata[8]);
        end
        bus_write(2'd0, 32'd1);
        address = 2'd3;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            checks++;
            if (led_out !== m_led || readdata !== m_read(address)) begin
                errors++;
                $display("FAIL reenable cyc %0d got %h/%h exp %h/%h", i, led_out, readdata, m_led, m_read(address));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            checks++;
            if (led_out !== m_led || readdata !== m_read(address)) begin
                errors++;
                $display("FAIL random cyc %0d got %h/%h exp %h/%h", i, led_out, readdata, m_led, m_read(address));
            end
            chipselect = 1'b0; write_n = 1'b1;
            pattern_in = 8'($urandom);
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) < 4) begin
                chipselect = 1'b1; write_n = 1'b0;
                case (address)
                    2'd0:    writedata = ($urandom_range(0, 4) != 0) ? 32'd1 : 32'd0;
                    2'd2:    writedata = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
                    default: writedata = $urandom;
                endcase
            end else if ($urandom_range(0, 99) < 5) begin
                chipselect = 1'b1;
            end
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_rd [4];
        exp_rd[0] = 32'd1; exp_rd[1] = 32'hFF; exp_rd[2] = 32'd0; exp_rd[3] = 32'h100;
        pattern_in = 8'hFF;
        bus_write(2'd0, 32'd1);
        bus_write(2'd1, 32'd200);
        bus_write(2'd3, 32'hFF);
        bus_write(2'd2, 32'd1);
        repeat (PERIOD + 300) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (led_out !== 8'h00 || led_out !== m_led) begin
            errors++; $display("FAIL async_reset_led got %h exp 00", led_out);
        end
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            checks++;
            if (readdata !== exp_rd[a]) begin
                errors++; $display("FAIL reset_readback addr %0d got %h exp %h", a, readdata, exp_rd[a]);
            end
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        address = 2'd3;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checks++;
            if (led_out !== m_led || readdata !== m_read(address)) begin
                errors++;
                $display("FAIL after_reset cyc %0d got %h/%h exp %h/%h", i, led_out, readdata, m_led, m_read(address));
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        pattern_in = 8'hA5;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        test_reset();
        test_pwm_duty();
        test_duty_update();
        test_blink();
        test_disable();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
